// File: rtl/sram_wb_ctrl_if.sv
// rtl/sram_wb_ctrl_if.sv - word-request bus between the line wrapper and the SRAM controller
interface sram_wb_ctrl_if;
  logic        wb_stb;
  logic [31:0] wb_addr;
  logic [3:0]  wb_we;
  logic [31:0] wb_din;
  logic [31:0] wb_dout;
  logic        wb_nak;

  modport master (
    output wb_stb, wb_addr, wb_we, wb_din,
    input  wb_dout, wb_nak
  );

  modport slave (
    input  wb_stb, wb_addr, wb_we, wb_din,
    output wb_dout, wb_nak
  );
endinterface

// File: rtl/sram_wb_ctrl.sv
// rtl/sram_wb_ctrl.sv - fixed-length 32-bit word access sequencer for a 3x16-bit async SRAM bank
module sram_wb_ctrl #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  sram_wb_ctrl_if.slave      wb,
  output logic [2:0]         sram_ce_n,
  output logic [2:0]         sram_oe_n,
  output logic [2:0]         sram_we_n,
  output logic [2:0]         sram_ub_n,
  output logic [2:0]         sram_lb_n,
  output logic [19:0]        sram_addr,
  inout  wire  [47:0]        sram_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);
  localparam logic [2:0] PINS_OFF = 3'b111;
  // Only chips 0 and 1 are ever selected; chip 2 bit stays high.
  localparam logic [2:0] PINS_ON  = 3'b100;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic        drive_q, drive_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] dout_q, dout_d;
  logic        nak_q, nak_d;
  logic [2:0]  ce_n_q, ce_n_d;
  logic [2:0]  oe_n_q, oe_n_d;
  logic [2:0]  we_n_q, we_n_d;
  logic [2:0]  ub_n_q, ub_n_d;
  logic [2:0]  lb_n_q, lb_n_d;
  logic [19:0] addr_q, addr_d;

  logic unused_bits;
  assign unused_bits = ^{wb.wb_addr[31:22], wb.wb_addr[1:0], sram_data[47:32]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      drive_q    <= 1'b0;
      wdata_q    <= '0;
      dout_q     <= '0;
      nak_q      <= 1'b0;
      ce_n_q     <= PINS_OFF;
      oe_n_q     <= PINS_OFF;
      we_n_q     <= PINS_OFF;
      ub_n_q     <= PINS_OFF;
      lb_n_q     <= PINS_OFF;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      drive_q    <= drive_d;
      wdata_q    <= wdata_d;
      dout_q     <= dout_d;
      nak_q      <= nak_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      ub_n_q     <= ub_n_d;
      lb_n_q     <= lb_n_d;
      addr_q     <= addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    drive_d    = drive_q;
    wdata_d    = wdata_q;
    dout_d     = dout_q;
    nak_d      = nak_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    ub_n_d     = ub_n_q;
    lb_n_d     = lb_n_q;
    addr_d     = addr_q;

    case (state_q)
      IDLE: begin
        if (wb.wb_stb) begin
          addr_d     = wb.wb_addr[21:2];
          ce_n_d     = PINS_ON;
          is_write_d = |wb.wb_we;
          cnt_d      = CNT_INIT;
          nak_d      = 1'b1;
          state_d    = ACCESS;
          if (|wb.wb_we) begin
            we_n_d  = PINS_ON;
            lb_n_d  = {1'b1, ~wb.wb_we[2], ~wb.wb_we[0]};
            ub_n_d  = {1'b1, ~wb.wb_we[3], ~wb.wb_we[1]};
            wdata_d = wb.wb_din;
            drive_d = 1'b1;
          end else begin
            oe_n_d  = PINS_ON;
            lb_n_d  = PINS_ON;
            ub_n_d  = PINS_ON;
          end
        end
      end

      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!is_write_q) begin
            dout_d = sram_data[31:0];
          end
          oe_n_d  = PINS_OFF;
          we_n_d  = PINS_OFF;
          state_d = HOLD;
        end
      end

      HOLD: begin
        // Address and write data stay one cycle past we_n rising for hold time.
        ce_n_d  = PINS_OFF;
        ub_n_d  = PINS_OFF;
        lb_n_d  = PINS_OFF;
        drive_d = 1'b0;
        nak_d   = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sram_data  = {16'hzzzz, drive_q ? wdata_q : 32'hzzzz_zzzz};
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_ub_n  = ub_n_q;
  assign sram_lb_n  = lb_n_q;
  assign sram_addr  = addr_q;
  assign wb.wb_dout = dout_q;
  assign wb.wb_nak  = nak_q;

endmodule

// File: tb/tb_sram_wb_ctrl.sv
// tb/tb_sram_wb_ctrl.sv - directed bench for sram_wb_ctrl with a behavioural SRAM bank
module tb_sram_wb_ctrl;
  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [19:0] sram_addr;
  wire  [47:0] sram_data;

  sram_wb_ctrl_if wb ();

  sram_wb_ctrl #(.ACCESS_CYCLES(AC)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb.slave),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n),
    .sram_addr (sram_addr),
    .sram_data (sram_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  logic        probe_en = 1'b0;
  logic [31:0] probe_pat = 32'h5A5A_A5A5;
  logic        model_rd;
  assign model_rd = ~sram_ce_n[0] & ~sram_oe_n[0];
  assign sram_data = (probe_en | model_rd)
                   ? {16'hzzzz, (probe_en ? probe_pat : mem[sram_addr[7:0]])}
                   : {48{1'bz}};

  always @(posedge clk) begin
    if (!sram_ce_n[0] && !sram_we_n[0]) begin
      if (!sram_lb_n[0]) mem[sram_addr[7:0]][7:0]   = sram_data[7:0];
      if (!sram_ub_n[0]) mem[sram_addr[7:0]][15:8]  = sram_data[15:8];
    end
    if (!sram_ce_n[1] && !sram_we_n[1]) begin
      if (!sram_lb_n[1]) mem[sram_addr[7:0]][23:16] = sram_data[23:16];
      if (!sram_ub_n[1]) mem[sram_addr[7:0]][31:24] = sram_data[31:24];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_released(input string tag);
    probe_en = 1'b1;
    #1;
    check_eq(tag, {16'd0, sram_data[31:0]}, {16'd0, probe_pat});
    probe_en = 1'b0;
    #1;
  endtask

  task automatic check_idle_pins(input string tag);
    check_eq({tag, "_pins"}, {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n},
             {5{3'b111}});
    check_eq({tag, "_nak"}, {47'd0, wb.wb_nak}, 48'd0);
  endtask

  // One request; exp_dout is wb_dout expected once the access completes.
  task automatic do_access(input string tag, input logic [31:0] addr, input logic [3:0] we,
                           input logic [31:0] din, input logic [31:0] exp_dout,
                           input logic [2:0] exp_ub, input logic [2:0] exp_lb);
    int n_nak;
    int n_str;
    logic wr;
    wr = (we != 4'd0);
    @(negedge clk);
    wb.wb_stb  = 1'b1;
    wb.wb_addr = addr;
    wb.wb_we   = we;
    wb.wb_din  = din;
    @(negedge clk);
    wb.wb_stb  = 1'b0;
    check_eq({tag, "_addr"}, {28'd0, sram_addr}, {28'd0, 20'(addr[21:2])});
    check_eq({tag, "_ce"}, {45'd0, sram_ce_n}, {45'd0, 3'b100});
    check_eq({tag, "_ublb"}, {42'd0, sram_ub_n, sram_lb_n}, {42'd0, exp_ub, exp_lb});
    check_eq({tag, "_oewe"}, {42'd0, sram_oe_n, sram_we_n},
             wr ? {42'd0, 3'b111, 3'b100} : {42'd0, 3'b100, 3'b111});
    n_nak = 0;
    n_str = 0;
    for (int i = 0; i < 20; i++) begin
      if (!wb.wb_nak) break;
      n_nak++;
      if ((sram_oe_n != 3'b111) || (sram_we_n != 3'b111)) begin
        n_str++;
        check_eq({tag, "_bus"}, {16'd0, sram_data[31:0]}, {16'd0, wr ? din : exp_dout});
      end else begin
        check_eq({tag, "_hold_dout"}, {16'd0, wb.wb_dout}, {16'd0, exp_dout});
        check_eq({tag, "_hold_addr"}, {28'd0, sram_addr}, {28'd0, 20'(addr[21:2])});
        if (wr) check_eq({tag, "_hold_data"}, {16'd0, sram_data[31:0]}, {16'd0, din});
      end
      @(negedge clk);
    end
    check_eq({tag, "_nak_cycles"}, 48'(n_nak), 48'(AC + 1));
    check_eq({tag, "_strobe_cycles"}, 48'(n_str), 48'(AC));
    check_idle_pins({tag, "_end"});
    check_eq({tag, "_dout"}, {16'd0, wb.wb_dout}, {16'd0, exp_dout});
    check_released({tag, "_release"});
  endtask

  initial begin
    int k;
    int last_cyc;
    logic prev_nak;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 16; i++) mem[8'h40 + i] = 32'hC0DE_0000 + 32'(i);
    wb.wb_stb  = 1'b0;
    wb.wb_addr = '0;
    wb.wb_we   = '0;
    wb.wb_din  = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_idle_pins("reset");
    check_eq("reset_dout", {16'd0, wb.wb_dout}, 48'd0);
    check_eq("reset_addr", {28'd0, sram_addr}, 48'd0);
    check_released("reset_release");

    do_access("wr_full", 32'h0000_0010, 4'hF, 32'h1234_5678, 32'h0, 3'b100, 3'b100);
    check_eq("wr_full_mem", {16'd0, mem[4]}, {16'd0, 32'h1234_5678});
    do_access("rd_full", 32'h0000_0010, 4'h0, 32'h0, 32'h1234_5678, 3'b100, 3'b100);

    do_access("wr_pre", 32'h0000_0020, 4'hF, 32'h1122_3344, 32'h1234_5678, 3'b100, 3'b100);
    do_access("wr_part", 32'h0000_0020, 4'b0100, 32'hAABB_CCDD, 32'h1234_5678,
              3'b111, 3'b101);
    do_access("rd_part", 32'h0000_0020, 4'h0, 32'h0, 32'h11BB_3344, 3'b100, 3'b100);

    // Back-to-back reads with wb_stb held high.
    @(negedge clk);
    prev_nak   = wb.wb_nak;
    k          = 0;
    last_cyc   = 0;
    wb.wb_stb  = 1'b1;
    wb.wb_addr = 32'h100;
    wb.wb_we   = 4'h0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (wb.wb_nak && !prev_nak) begin
        check_eq("seq_addr", {28'd0, sram_addr}, 48'(20'h40 + 20'(k)));
        if (k > 0) begin
          check_eq("seq_spacing", 48'(cyc - last_cyc), 48'(AC + 2));
          check_eq("seq_dout", {16'd0, wb.wb_dout}, {16'd0, 32'hC0DE_0000 + 32'(k - 1)});
        end
        k++;
        last_cyc   = cyc;
        wb.wb_addr = 32'h100 + 32'(4 * k);
        if (k == 16) wb.wb_stb = 1'b0;
      end
      prev_nak = wb.wb_nak;
    end
    check_eq("seq_count", 48'(k), 48'd16);
    check_eq("seq_last_dout", {16'd0, wb.wb_dout}, {16'd0, 32'hC0DE_000F});
    check_idle_pins("seq_end");

    // Reset in the middle of a write access.
    @(negedge clk);
    wb.wb_stb  = 1'b1;
    wb.wb_addr = 32'h0000_03FC;
    wb.wb_we   = 4'hF;
    wb.wb_din  = 32'hDEAD_BEEF;
    @(negedge clk);
    wb.wb_stb  = 1'b0;
    check_eq("rst_mid_we_before", {45'd0, sram_we_n}, {45'd0, 3'b100});
    rst = 1'b1;
    #1;
    check_idle_pins("rst_mid");
    check_released("rst_mid_release");
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid_mem", {16'd0, mem[8'hFF]}, 48'd0);
    check_eq("rst_mid_dout", {16'd0, wb.wb_dout}, 48'd0);
    do_access("rd_after_rst", 32'h0000_0010, 4'h0, 32'h0, 32'h1234_5678, 3'b100, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
